// File: rtl/data_mem_responder.sv
// Wait-stated data memory target for RV32 loads/stores over valid/ready request and response channels.
// One request is accepted, held for LATENCY cycles, then answered with extended load data or a store ack.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  LAST_CNT = (LATENCY == 32'd0) ? 4'd0 : 4'(LATENCY - 32'd1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state_r;
  logic [3:0]    cnt_r;
  logic          req_ready_r;
  logic          rsp_valid_r;
  logic [31:0]   rsp_rdata_r;
  logic          rsp_error_r;

  logic          write_r;
  logic [31:0]   addr_r;
  logic [1:0]    size_r;
  logic          unsigned_r;
  logic [31:0]   wdata_r;

  logic [31:0]   mem_r [DEPTH_WORDS];

  logic          accept_s;
  logic          enter_resp_s;
  logic          acc_write_s;
  logic [31:0]   acc_addr_s;
  logic [1:0]    acc_size_s;
  logic          acc_unsigned_s;
  logic [31:0]   acc_wdata_s;
  logic [31:0]   off_s;
  logic          in_range_s;
  logic [AW-1:0] idx_s;
  logic [1:0]    lane_s;
  logic          acc_err_s;
  logic [31:0]   rd_word_s;
  logic [31:0]   rsp_data_s;
  logic [3:0]    wr_be_s;
  logic [31:0]   wr_data_s;

  function automatic logic access_error(input logic [1:0] lane, input logic [1:0] size,
                                        input logic in_range);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = lane[0];
      2'b10:   bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad || !in_range;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {lane, 3'b000};
    case (size)
      2'b00:   res = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   res = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] store_lanes(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  assign accept_s = req_valid && req_ready_r;

  // With zero latency the access happens on the accept edge, so live fields are used while idle
  always_comb begin
    if (state_r == IDLE) begin
      acc_write_s    = req_write;
      acc_addr_s     = req_addr;
      acc_size_s     = req_size;
      acc_unsigned_s = req_unsigned;
      acc_wdata_s    = req_wdata;
    end else begin
      acc_write_s    = write_r;
      acc_addr_s     = addr_r;
      acc_size_s     = size_r;
      acc_unsigned_s = unsigned_r;
      acc_wdata_s    = wdata_r;
    end
  end

  assign off_s      = acc_addr_s - BASE_ADDR;
  assign in_range_s = ({1'b0, off_s} < SPAN);
  assign idx_s      = off_s[AW+1:2];
  assign lane_s     = acc_addr_s[1:0];
  assign acc_err_s  = access_error(lane_s, acc_size_s, in_range_s);
  assign rd_word_s  = mem_r[idx_s];
  assign wr_be_s    = store_lanes(acc_size_s, lane_s);
  assign wr_data_s  = store_data(acc_size_s, acc_wdata_s);

  // Marks the edge on which the RAM is accessed and the response is captured
  always_comb begin
    case (state_r)
      IDLE:    enter_resp_s = accept_s && (LATENCY == 32'd0);
      WAIT:    enter_resp_s = (cnt_r == LAST_CNT);
      default: enter_resp_s = 1'b0;
    endcase
  end

  // Response payload: zero for stores and errors, extended lane data for loads
  always_comb begin
    if (acc_err_s || acc_write_s) begin
      rsp_data_s = 32'd0;
    end else begin
      rsp_data_s = load_extend(rd_word_s, lane_s, acc_size_s, acc_unsigned_s);
    end
  end

  // RAM write port; a store pending when reset arrives is dropped
  always_ff @(posedge clock) begin
    if (!reset && enter_resp_s && acc_write_s && !acc_err_s) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be_s[i]) mem_r[idx_s][8*i +: 8] <= wr_data_s[8*i +: 8];
      end
    end
  end

  // Handshake FSM, request latch, wait counter and registered response
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'd0;
      rsp_error_r <= 1'b0;
      write_r     <= 1'b0;
      addr_r      <= 32'd0;
      size_r      <= 2'd0;
      unsigned_r  <= 1'b0;
      wdata_r     <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            write_r     <= req_write;
            addr_r      <= req_addr;
            size_r      <= req_size;
            unsigned_r  <= req_unsigned;
            wdata_r     <= req_wdata;
            cnt_r       <= 4'd0;
            req_ready_r <= 1'b0;
            if (enter_resp_s) begin
              state_r     <= RESP;
              rsp_valid_r <= 1'b1;
              rsp_rdata_r <= rsp_data_s;
              rsp_error_r <= acc_err_s;
            end else begin
              state_r <= WAIT;
            end
          end
        end
        WAIT: begin
          if (enter_resp_s) begin
            state_r     <= RESP;
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= rsp_data_s;
            rsp_error_r <= acc_err_s;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_r     <= IDLE;
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          rsp_valid_r <= 1'b0;
          req_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_error = rsp_error_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=2/base 0 instance and a LATENCY=0/base 0x400 instance,
// driven by directed and random transactions checked against a byte-array memory model.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned BYTES = DEPTH * 4;

  logic        clock;
  logic        reset;
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_write    [2];
  logic [31:0] req_addr     [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [31:0] req_wdata    [2];
  logic        rsp_valid    [2];
  logic        rsp_ready    [2];
  logic [31:0] rsp_rdata    [2];
  logic        rsp_error    [2];

  logic [7:0]  ref_mem [2][BYTES];
  int          n_checks;
  int          n_fail;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) u_lat2 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0])
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0), .BASE_ADDR(32'h0000_0400)) u_lat0 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? 32'h0000_0000 : 32'h0000_0400;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // Reference: bytes in little-endian order, sized by 1<<size, errors leave memory untouched
  function automatic void model(input int d, input bit wr, input logic [31:0] addr,
                                input logic [1:0] size, input bit uns, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic err);
    logic [31:0] off;
    int          n;
    off = addr - base_of(d);
    n   = 1 << size;
    err = (size == 2'd3) || (addr % n != 0) || (off >= BYTES);
    rd  = 32'd0;
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        if (wr) ref_mem[d][off + i] = 8'(wdata >> (8 * i));
        else    rd = rd | (32'(ref_mem[d][off + i]) << (8 * i));
      end
      if (wr) rd = 32'd0;
      else if (!uns && n < 4 && rd[8*n-1]) rd = rd | ~((32'd1 << (8 * n)) - 32'd1);
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xact(input int d, input bit wr, input logic [31:0] addr, input logic [1:0] size,
                      input bit uns, input logic [31:0] wdata, input int hold,
                      output logic [31:0] obs_rd, output logic obs_err);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          cyc;
    model(d, wr, addr, size, uns, wdata, exp_rd, exp_err);
    @(negedge clock);
    req_valid[d]    = 1'b1;
    req_write[d]    = wr;
    req_addr[d]     = addr;
    req_size[d]     = size;
    req_unsigned[d] = uns;
    req_wdata[d]    = wdata;
    rsp_ready[d]    = (hold == 0);
    cyc = 0;
    while (req_ready[d] !== 1'b1 && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    check("req_ready_idle", {31'd0, req_ready[d]}, 32'd1);
    @(posedge clock);
    #1;
    req_valid[d]    = 1'b0;
    req_write[d]    = 1'($urandom());
    req_addr[d]     = $urandom();
    req_size[d]     = 2'($urandom());
    req_unsigned[d] = 1'($urandom());
    req_wdata[d]    = $urandom();
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (rsp_valid[d] !== 1'b1 && cyc < 40);
    check("latency", 32'(cyc), 32'(lat_of(d) + 1));
    obs_rd  = rsp_rdata[d];
    obs_err = rsp_error[d];
    check("rsp_error", {31'd0, obs_err}, {31'd0, exp_err});
    check("rsp_rdata", obs_rd, exp_rd);
    for (int i = 0; i < hold; i++) begin
      check("bp_valid", {31'd0, rsp_valid[d]}, 32'd1);
      check("bp_rdata", rsp_rdata[d], exp_rd);
      check("bp_req_ready", {31'd0, req_ready[d]}, 32'd0);
      @(negedge clock);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("ready_after_hs", {31'd0, req_ready[d]}, 32'd1);
    check("valid_after_hs", {31'd0, rsp_valid[d]}, 32'd0);
  endtask

  task automatic spec_seq(input int d);
    logic [31:0] rd;
    logic        er;
    logic [31:0] b;
    b = base_of(d);
    xact(d, 1'b1, b + 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF, 0, rd, er);
    xact(d, 1'b0, b + 32'h10, 2'b10, 1'b0, 32'h0, 0, rd, er);
    check("lw_deadbeef", rd, 32'hDEAD_BEEF);
    xact(d, 1'b1, b + 32'h13, 2'b00, 1'b0, 32'h0000_0080, 0, rd, er);
    xact(d, 1'b0, b + 32'h13, 2'b00, 1'b0, 32'h0, 0, rd, er);
    check("lb_neg", rd, 32'hFFFF_FF80);
    xact(d, 1'b0, b + 32'h13, 2'b00, 1'b1, 32'h0, 0, rd, er);
    check("lbu", rd, 32'h0000_0080);
    xact(d, 1'b0, b + 32'h10, 2'b10, 1'b0, 32'h0, 0, rd, er);
    check("lw_merged", rd, 32'h80AD_BEEF);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = 32'd0; req_size[d] = 2'd0;
      req_unsigned[d] = 1'b0; req_wdata[d] = 32'd0; rsp_ready[d] = 1'b1;
    end
    repeat (3) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      check("rst_req_ready", {31'd0, req_ready[d]}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata[d], 32'd0);
      check("rst_rsp_error", {31'd0, rsp_error[d]}, 32'd0);
    end
    reset = 1'b0;

    // Fill both memories so every model byte is known
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < DEPTH; w++)
        xact(d, 1'b1, base_of(d) + 32'(4 * w), 2'b10, 1'b0, $urandom(), 0, rd, er);

    spec_seq(0);
    xact(0, 1'b0, 32'h11, 2'b01, 1'b0, 32'h0, 0, rd, er);
    check("lh_misaligned_err", {31'd0, er}, 32'd1);
    check("lh_misaligned_data", rd, 32'd0);
    xact(0, 1'b1, 32'h12, 2'b10, 1'b0, 32'h1111_2222, 0, rd, er);
    check("sw_misaligned_err", {31'd0, er}, 32'd1);
    xact(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, rd, er);
    check("lw_unchanged", rd, 32'h80AD_BEEF);
    xact(0, 1'b0, 32'(4 * DEPTH), 2'b10, 1'b0, 32'h0, 0, rd, er);
    check("lw_out_of_range", {31'd0, er}, 32'd1);
    xact(0, 1'b0, 32'h14, 2'b11, 1'b0, 32'h0, 0, rd, er);
    check("illegal_size", {31'd0, er}, 32'd1);
    xact(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 5, rd, er);
    check("bp_load", rd, 32'h80AD_BEEF);

    // Reset while a store is waiting: the store must never land
    @(negedge clock);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h20;
    req_size[0] = 2'b10; req_wdata[0] = 32'h0000_1234;
    @(posedge clock);
    #1 req_valid[0] = 1'b0;
    @(negedge clock);
    check("pre_rst_busy", {31'd0, req_ready[0]}, 32'd0);
    reset = 1'b1;
    #1;
    check("mid_rst_req_ready", {31'd0, req_ready[0]}, 32'd1);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    check("mid_rst_rsp_rdata", rsp_rdata[0], 32'd0);
    check("mid_rst_rsp_error", {31'd0, rsp_error[0]}, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    xact(0, 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 0, rd, er);

    spec_seq(1);
    xact(1, 1'b0, 32'h0000_03FC, 2'b10, 1'b0, 32'h0, 0, rd, er);
    check("below_base_err", {31'd0, er}, 32'd1);

    // Random mix around the legal window of each instance
    for (int k = 0; k < 300; k++) begin
      int d;
      d = k % 2;
      a = base_of(d) - 32'd8 + 32'($urandom_range(0, BYTES + 15));
      xact(d, 1'($urandom()), a, ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
           1'($urandom()), $urandom(), ($urandom_range(0, 7) == 0) ? 2 : 0, rd, er);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
